// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter and instruction register,
// steps through FILL -> RUN and parks in HALT on a detected self-loop.
// Execution is gated by run (free-running) or a single-step rising edge.
module fetch_sequencer #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [DATA_W-1:0] bus,
    input  logic              loadBarIR,
    input  logic              doJumpBar,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] rom_addr,
    output logic              halted,
    output logic              fill,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;
    logic   stepQ;
    logic   stepEdge;
    logic   enable;
    logic   selfLoop;

    // Saturating increment for the executed-cycle counter.
    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] value);
        if (value == {COUNT_W{1'b1}}) begin
            satInc = value;
        end else begin
            satInc = value + 1'b1;
        end
    endfunction

    // The ROM is addressed directly by the program counter.
    assign rom_addr = pc;

    // Advance on every cycle in run mode, or once per rising step edge otherwise.
    always_comb begin
        stepEdge = step & ~stepQ;
        enable   = run | stepEdge;
        selfLoop = ~doJumpBar & loadBarIR & (bus == pc);
    end

    // Sequencer state, fetch registers and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            stepQ       <= 1'b0;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            fill        <= 1'b1;
            halted      <= 1'b0;
        end else begin
            stepQ <= step;
            case (state)
                FILL: begin
                    if (enable) begin
                        ir    <= rom_data;
                        pc    <= pc + 1'b1;
                        state <= RUN;
                        fill  <= 1'b0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (!loadBarIR) begin
                            ir <= bus;
                        end
                        if (!doJumpBar) begin
                            pc <= bus;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                        instr_count <= satInc(instr_count);
                        // A jump to itself without a new instruction can never progress.
                        if (selfLoop) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                    fill   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, fill, run, jumps, wrap,
// single-step edge detection, self-loop halt and reset out of halt.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [7:0]  romData;
    logic [7:0]  bus;
    logic        loadBarIR;
    logic        doJumpBar;
    logic [7:0]  ir;
    logic [7:0]  pc;
    logic [7:0]  romAddr;
    logic        halted;
    logic        fill;
    logic [15:0] instrCount;

    logic [7:0]  rom [256];
    int          checks   = 0;
    int          failures = 0;

    // Expected architectural state, advanced by hand in each test.
    logic [7:0]  expPc;
    logic [7:0]  expIr;
    logic [15:0] expCnt;

    always #5 clk = ~clk;

    assign romData = rom[romAddr];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .rom_data    (romData),
        .bus         (bus),
        .loadBarIR   (loadBarIR),
        .doJumpBar   (doJumpBar),
        .ir          (ir),
        .pc          (pc),
        .rom_addr    (romAddr),
        .halted      (halted),
        .fill        (fill),
        .instr_count (instrCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic r, input logic s, input logic lb, input logic jb, input logic [7:0] b);
        run = r; step = s; loadBarIR = lb; doJumpBar = jb; bus = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        tick();
        checks++;
        if ({fill, halted, pc, ir, instrCount} !== {1'b1, 1'b0, 8'h00, 8'h00, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state got f=%b h=%b pc=%h ir=%h cnt=%h want f=1 h=0 pc=00 ir=00 cnt=0000", fill, halted, pc, ir, instrCount);
        end
        tick();
        tick();
        checks++;
        if ({fill, pc, ir} !== {1'b1, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL reset_held got f=%b pc=%h ir=%h want f=1 pc=00 ir=00", fill, pc, ir);
        end
    endtask

    task automatic test_fill_hold();
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({fill, pc, ir, instrCount} !== {1'b1, 8'h00, 8'h00, 16'h0000}) begin
            failures++;
            $display("FAIL fill_hold got f=%b pc=%h ir=%h cnt=%h want f=1 pc=00 ir=00 cnt=0000", fill, pc, ir, instrCount);
        end
    endtask

    task automatic test_fill();
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        tick();
        expPc = 8'h01; expIr = 8'h5A; expCnt = 16'h0000;
        checks++;
        if ({fill, halted, pc, ir, instrCount} !== {1'b0, 1'b0, expPc, expIr, expCnt}) begin
            failures++;
            $display("FAIL fill_load got f=%b h=%b pc=%h ir=%h cnt=%h want f=0 h=0 pc=%h ir=%h cnt=%h", fill, halted, pc, ir, instrCount, expPc, expIr, expCnt);
        end
        checks++;
        if (romAddr !== 8'h01) begin
            failures++;
            $display("FAIL rom_addr got %h want 01", romAddr);
        end
    endtask

    task automatic test_run_increment();
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);
        tick();
        expPc = 8'h02; expCnt = 16'h0001;
        checks++;
        if ({pc, ir, instrCount} !== {expPc, expIr, expCnt}) begin
            failures++;
            $display("FAIL run_incr got pc=%h ir=%h cnt=%h want pc=%h ir=%h cnt=%h", pc, ir, instrCount, expPc, expIr, expCnt);
        end
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
        tick();
        expPc = 8'h03; expIr = 8'h77; expCnt = 16'h0002;
        checks++;
        if ({pc, ir, instrCount} !== {expPc, expIr, expCnt}) begin
            failures++;
            $display("FAIL load_ir got pc=%h ir=%h cnt=%h want pc=%h ir=%h cnt=%h", pc, ir, instrCount, expPc, expIr, expCnt);
        end
    endtask

    task automatic test_wrap();
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
        tick();
        expPc = 8'hFF; expCnt = 16'h0003;
        checks++;
        if ({pc, ir, instrCount, halted} !== {expPc, expIr, expCnt, 1'b0}) begin
            failures++;
            $display("FAIL jump_ff got pc=%h ir=%h cnt=%h h=%b want pc=%h ir=%h cnt=%h h=0", pc, ir, instrCount, halted, expPc, expIr, expCnt);
        end
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 8'h12);
        tick();
        expPc = 8'h00; expCnt = 16'h0004;
        checks++;
        if ({pc, ir, instrCount} !== {expPc, expIr, expCnt}) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h ir=%h cnt=%h want pc=%h ir=%h cnt=%h", pc, ir, instrCount, expPc, expIr, expCnt);
        end
    endtask

    task automatic test_both_strobes();
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        tick();
        expPc = 8'h33; expIr = 8'h33; expCnt = 16'h0006;
        checks++;
        if ({pc, ir, instrCount, halted} !== {expPc, expIr, expCnt, 1'b0}) begin
            failures++;
            $display("FAIL both_strobes got pc=%h ir=%h cnt=%h h=%b want pc=%h ir=%h cnt=%h h=0", pc, ir, instrCount, halted, expPc, expIr, expCnt);
        end
        // Self-jump that also loads IR must not halt.
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        tick();
        expCnt = 16'h0007;
        checks++;
        if ({pc, ir, instrCount, halted} !== {expPc, expIr, expCnt, 1'b0}) begin
            failures++;
            $display("FAIL self_jump_load got pc=%h ir=%h cnt=%h h=%b want pc=%h ir=%h cnt=%h h=0", pc, ir, instrCount, halted, expPc, expIr, expCnt);
        end
    endtask

    task automatic test_run_hold();
        setIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
        tick();
        tick();
        checks++;
        if ({pc, ir, instrCount, halted, fill} !== {expPc, expIr, expCnt, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL run_hold got pc=%h ir=%h cnt=%h want pc=%h ir=%h cnt=%h", pc, ir, instrCount, expPc, expIr, expCnt);
        end
    endtask

    task automatic test_step();
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
        tick();
        expPc = 8'h04; expCnt = 16'h0008;
        setIn(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        expPc = 8'h05; expCnt = 16'h0009;
        checks++;
        if ({pc, instrCount} !== {expPc, expCnt}) begin
            failures++;
            $display("FAIL step_first got pc=%h cnt=%h want pc=%h cnt=%h", pc, instrCount, expPc, expCnt);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({pc, ir, instrCount} !== {expPc, expIr, expCnt}) begin
            failures++;
            $display("FAIL step_held got pc=%h ir=%h cnt=%h want pc=%h ir=%h cnt=%h", pc, ir, instrCount, expPc, expIr, expCnt);
        end
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        expPc = 8'h06; expCnt = 16'h000A;
        checks++;
        if ({pc, instrCount} !== {expPc, expCnt}) begin
            failures++;
            $display("FAIL step_second got pc=%h cnt=%h want pc=%h cnt=%h", pc, instrCount, expPc, expCnt);
        end
    endtask

    task automatic test_halt();
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        while (expCnt < 16'h0040) begin
            tick();
            expPc = expPc + 8'h01;
            expCnt = expCnt + 16'h0001;
        end
        checks++;
        if ({pc, instrCount} !== {expPc, expCnt}) begin
            failures++;
            $display("FAIL free_run got pc=%h cnt=%h want pc=%h cnt=%h", pc, instrCount, expPc, expCnt);
        end
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        tick();
        expPc = 8'h20; expCnt = 16'h0041;
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        tick();
        expCnt = 16'h0042;
        checks++;
        if ({pc, ir, instrCount, halted, fill} !== {expPc, expIr, expCnt, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL self_loop_halt got pc=%h ir=%h cnt=%h h=%b f=%b want pc=%h ir=%h cnt=%h h=1 f=0", pc, ir, instrCount, halted, fill, expPc, expIr, expCnt);
        end
        setIn(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        tick();
        step = 1'b0;
        tick();
        setIn(1'b0, 1'b1, 1'b1, 1'b1, 8'h66);
        tick();
        checks++;
        if ({pc, ir, instrCount, halted, fill} !== {expPc, expIr, expCnt, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL halt_hold got pc=%h ir=%h cnt=%h h=%b want pc=%h ir=%h cnt=%h h=1", pc, ir, instrCount, halted, expPc, expIr, expCnt);
        end
    endtask

    task automatic test_reset_from_halt();
        reset = 1'b1;
        setIn(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        tick();
        checks++;
        if ({fill, halted, pc, ir, instrCount} !== {1'b1, 1'b0, 8'h00, 8'h00, 16'h0000}) begin
            failures++;
            $display("FAIL reset_halt got f=%b h=%b pc=%h ir=%h cnt=%h want f=1 h=0 pc=00 ir=00 cnt=0000", fill, halted, pc, ir, instrCount);
        end
        // Release with step still high: step_q was cleared, so this edge fills.
        reset = 1'b0;
        setIn(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        checks++;
        if ({fill, pc, ir, instrCount} !== {1'b0, 8'h01, 8'h5A, 16'h0000}) begin
            failures++;
            $display("FAIL step_fill got f=%b pc=%h ir=%h cnt=%h want f=0 pc=01 ir=5a cnt=0000", fill, pc, ir, instrCount);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i ^ 8'hC0);
        rom[0] = 8'h5A;
        reset = 1'b1;
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        test_reset();
        test_fill_hold();
        test_fill();
        test_run_increment();
        test_wrap();
        test_both_strobes();
        test_run_hold();
        test_step();
        test_halt();
        test_reset_from_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
